// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and helpers for the keypad scanner
// Purpose : FSM state encoding, keypad geometry and key-code packing.
// Exports : state_t, ROWS, COLS, key_pack(), row_drive()
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN       = 2'd0,
    ST_DEBOUNCE_P = 2'd1,
    ST_HOLD       = 2'd2,
    ST_RELEASE_D  = 2'd3
  } state_t;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  // {row, col_idx}; col_idx is the lowest column reading low, so with
  // several keys down in one row the lowest column wins.
  function automatic logic [3:0] key_pack(input logic [1:0] row, input logic [3:0] col_n);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (!col_n[i]) idx = i[1:0];
    end
    return {row, idx};
  endfunction

  // Active-low one-hot row drive for a row index.
  function automatic logic [3:0] row_drive(input logic [1:0] row);
    return ~(4'b0001 << row);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous inputs
// Purpose : brings an asynchronous bus into the clk domain (2-cycle latency).
// Ports   : clk, rst (sync, active-high), d (async in), q (synchronized out)
module sync_2ff #(
  parameter int                 WIDTH     = 4,
  parameter logic [WIDTH-1:0]   RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 active-low matrix keypad scanner with debounce
// Purpose : drives one row low at a time, samples columns, debounces press and
//           release, and presents a 4-bit key code over a valid/ready handshake.
// Ports   : clk, rst (sync, active-high)
//           col_i[3:0]  keypad columns, active-low, asynchronous
//           row_o[3:0]  row drive, active-low, exactly one bit low
//           key_code    {row_idx, col_idx} of the accepted key
//           key_valid   key_code holds an unconsumed key
//           key_ready   consumer accepts on key_valid & key_ready
//           key_pressed high from press accept to release accept
//           key_overrun 1-cycle pulse when a key is dropped because one is pending
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_i,
  output logic [3:0] row_o,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_pressed,
  output logic       key_overrun
);

  localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [3:0]       w_col_s;
  logic [CNT_W-1:0] w_cnt_inc;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_row;
  logic [3:0]       r_row_o;
  logic [3:0]       r_latched;
  logic [3:0]       r_code;
  logic             r_valid;
  logic             r_pressed;
  logic             r_overrun;

  sync_2ff #(
    .WIDTH     (4),
    .RESET_VAL (4'hF)
  ) u_col_sync (
    .clk (clk),
    .rst (rst),
    .d   (col_i),
    .q   (w_col_s)
  );

  // One counter serves dwell, press-stable and release-stable timing since
  // only one of them is active in any state; it holds at its ceiling.
  assign w_cnt_inc = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + CNT_ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_SCAN;
      r_cnt     <= '0;
      r_row     <= 2'd0;
      r_row_o   <= 4'b1110;
      r_latched <= 4'hF;
      r_code    <= 4'h0;
      r_valid   <= 1'b0;
      r_pressed <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;

      // Consumption; a same-cycle commit below overrides this and keeps valid high.
      if (r_valid && key_ready) r_valid <= 1'b0;

      case (r_state)
        ST_SCAN: begin
          if (r_cnt == SCAN_LAST) begin
            r_cnt <= '0;
            if (w_col_s == 4'hF) begin
              r_row   <= r_row + 2'd1;
              r_row_o <= row_drive(r_row + 2'd1);
            end else begin
              r_latched <= w_col_s;
              r_state   <= ST_DEBOUNCE_P;
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        ST_DEBOUNCE_P: begin
          if (w_col_s == r_latched) begin
            if (r_cnt == DEB_LAST) begin
              r_cnt     <= '0;
              r_state   <= ST_HOLD;
              r_pressed <= 1'b1;
              // A pending key that is not being taken this cycle wins;
              // the new one is dropped and flagged.
              if (!r_valid || key_ready) begin
                r_code  <= key_pack(r_row, r_latched);
                r_valid <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end else begin
            // Bounce: retry the same row from a fresh dwell.
            r_cnt   <= '0;
            r_state <= ST_SCAN;
          end
        end

        ST_HOLD: begin
          if (w_col_s == 4'hF) begin
            r_cnt   <= '0;
            r_state <= ST_RELEASE_D;
          end
        end

        ST_RELEASE_D: begin
          if (w_col_s == 4'hF) begin
            if (r_cnt == DEB_LAST) begin
              r_cnt     <= '0;
              r_pressed <= 1'b0;
              r_row     <= r_row + 2'd1;
              r_row_o   <= row_drive(r_row + 2'd1);
              r_state   <= ST_SCAN;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end else begin
            r_cnt   <= '0;
            r_state <= ST_HOLD;
          end
        end

        default: begin
          r_cnt   <= '0;
          r_state <= ST_SCAN;
        end
      endcase
    end
  end

  assign row_o       = r_row_o;
  assign key_code    = r_code;
  assign key_valid   = r_valid;
  assign key_pressed = r_pressed;
  assign key_overrun = r_overrun;

endmodule
